// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned REG_ID_W  = 2;

    localparam logic [1:0] ST_WARMUP_ENC   = 2'd0;
    localparam logic [1:0] ST_RUN_ENC      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_HALT_ENC     = 2'd3;

    typedef enum logic [1:0] {
        ST_WARMUP   = ST_WARMUP_ENC,
        ST_RUN      = ST_RUN_ENC,
        ST_MEM_WAIT = ST_MEM_WAIT_ENC,
        ST_HALT     = ST_HALT_ENC
    } state_e;

    // True when a writing producer's dest matches a source the ID instruction actually reads.
    function automatic logic reads_dest(
        input logic [REG_ID_W-1:0] rs,
        input logic [REG_ID_W-1:0] rt,
        input logic                use_rs,
        input logic                use_rt,
        input logic [REG_ID_W-1:0] rd,
        input logic                wr
    );
        return wr & ((use_rs & (rs == rd)) | (use_rt & (rt == rd)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/condition inputs and stage-register controls between the pipeline and the sequencer.
// master = sequencer (drives enables/flushes), slave = pipeline datapath.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_ID_W-1:0] id_rs;
    logic [REG_ID_W-1:0] id_rt;
    logic                id_use_rs;
    logic                id_use_rt;
    logic [REG_ID_W-1:0] idex_rd;
    logic                idex_regwrite;
    logic                idex_memread;
    logic [REG_ID_W-1:0] exmem_rd;
    logic                exmem_regwrite;
    logic [REG_ID_W-1:0] memwb_rd;
    logic                memwb_regwrite;
    logic                ex_redirect;
    logic                imem_ready;
    logic                dmem_req;
    logic                dmem_ready;
    logic                wb_is_done;

    logic                pc_we;
    logic                ifid_we;
    logic                idex_we;
    logic                exmem_we;
    logic                memwb_we;
    logic                ifid_flush;
    logic                idex_flush;
    logic                exmem_flush;
    logic                halted;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  idex_rd, idex_regwrite, idex_memread,
        input  exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
        input  ex_redirect, imem_ready, dmem_req, dmem_ready, wb_is_done,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        output ifid_flush, idex_flush, exmem_flush, halted, stall_cnt
    );

    modport slave (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output idex_rd, idex_regwrite, idex_memread,
        output exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
        output ex_redirect, imem_ready, dmem_req, dmem_ready, wb_is_done,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        input  ifid_flush, idex_flush, exmem_flush, halted, stall_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard compare for the instruction in ID.
// HAZARD_FORWARD_EN: forwarding present, only load-use stalls; otherwise any in-flight writer stalls.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ID_W-1:0] id_rs_i,
    input  logic [REG_ID_W-1:0] id_rt_i,
    input  logic                id_use_rs_i,
    input  logic                id_use_rt_i,
    input  logic [REG_ID_W-1:0] idex_rd_i,
    input  logic                idex_regwrite_i,
    input  logic                idex_memread_i,
    input  logic [REG_ID_W-1:0] exmem_rd_i,
    input  logic                exmem_regwrite_i,
    input  logic [REG_ID_W-1:0] memwb_rd_i,
    input  logic                memwb_regwrite_i,
    output logic                hazard_o
);

`ifdef HAZARD_FORWARD_EN
    logic unused_c;
    assign unused_c = ^{exmem_rd_i, exmem_regwrite_i, memwb_rd_i, memwb_regwrite_i};

    assign hazard_o = reads_dest(id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
                                 idex_rd_i, idex_regwrite_i & idex_memread_i);
`else
    logic unused_c;
    assign unused_c = idex_memread_i;

    // Regfile writes at end of cycle, so MEM/WB is still a hazard source.
    assign hazard_o = reads_dest(id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
                                 idex_rd_i, idex_regwrite_i)
                    | reads_dest(id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
                                 exmem_rd_i, exmem_regwrite_i)
                    | reads_dest(id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
                                 memwb_rd_i, memwb_regwrite_i);
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: warm-up, hazard stalls, memory waits, HLT drain.
// Optional macro HAZARD_FORWARD_EN selects load-use-only hazard detection.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input logic                    clk,
    input logic                    reset_n,
    pipeline_hazard_ctrl_if.master bus
);

    localparam int unsigned WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic hazard_c;
    logic freeze_c;
    logic pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs_i          (bus.id_rs),
        .id_rt_i          (bus.id_rt),
        .id_use_rs_i      (bus.id_use_rs),
        .id_use_rt_i      (bus.id_use_rt),
        .idex_rd_i        (bus.idex_rd),
        .idex_regwrite_i  (bus.idex_regwrite),
        .idex_memread_i   (bus.idex_memread),
        .exmem_rd_i       (bus.exmem_rd),
        .exmem_regwrite_i (bus.exmem_regwrite),
        .memwb_rd_i       (bus.memwb_rd),
        .memwb_regwrite_i (bus.memwb_regwrite),
        .hazard_o         (hazard_c)
    );

    always_comb begin
        state_d       = state_q;
        warm_d        = warm_q;
        halted_d      = halted_q;
        cnt_d         = cnt_q;
        freeze_c      = 1'b0;
        pc_we_c       = 1'b0;
        ifid_we_c     = 1'b0;
        idex_we_c     = 1'b0;
        exmem_we_c    = 1'b0;
        memwb_we_c    = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;

        unique case (state_q)
            ST_WARMUP: begin
                ifid_flush_c  = 1'b1;
                idex_flush_c  = 1'b1;
                exmem_flush_c = 1'b1;
                warm_d        = warm_q + WARM_W'(1);
                if (warm_q == WARM_W'(WARMUP_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                // Once waiting, only dmem_ready releases the freeze.
                freeze_c = (state_q == ST_MEM_WAIT) ? !bus.dmem_ready
                                                    : (bus.dmem_req & !bus.dmem_ready);
                if (freeze_c) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d    = ST_RUN;
                    pc_we_c    = 1'b1;
                    ifid_we_c  = 1'b1;
                    idex_we_c  = 1'b1;
                    exmem_we_c = 1'b1;
                    memwb_we_c = 1'b1;
                    if (bus.ex_redirect) begin
                        ifid_flush_c = 1'b1;
                        idex_flush_c = 1'b1;
                    end else if (hazard_c) begin
                        pc_we_c      = 1'b0;
                        ifid_we_c    = 1'b0;
                        idex_flush_c = 1'b1;
                    end else if (!bus.imem_ready) begin
                        pc_we_c      = 1'b0;
                        ifid_flush_c = 1'b1;
                    end
                end
                if (bus.wb_is_done) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
                if (!pc_we_c && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_WARMUP;
            warm_q   <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.pc_we       = pc_we_c;
    assign bus.ifid_we     = ifid_we_c;
    assign bus.idex_we     = idex_we_c;
    assign bus.exmem_we    = exmem_we_c;
    assign bus.memwb_we    = memwb_we_c;
    assign bus.ifid_flush  = ifid_flush_c;
    assign bus.idex_flush  = idex_flush_c;
    assign bus.exmem_flush = exmem_flush_c;
    assign bus.halted      = halted_q;
    assign bus.stall_cnt   = cnt_q;

endmodule
